// File: rtl/dtim_arbiter.sv
// rtl/dtim_arbiter.sv - two-master round-robin arbiter with bounded burst locking for the DTIM data port
//
// Purpose: grants at most one DTIM beat per cycle to master 0 (BIU data path)
// or master 1 (debug loader / DMA). Grants are combinational from the request
// inputs and the registered arbitration state. Read data returns one cycle
// after grant to the master that issued the read.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mX_req/addr/wmask/wdata  master X beat request (wmask==0 is a read)
//   mX_lock                  master X wants to keep ownership for its next beat
//   mX_gnt                   master X beat accepted this cycle
//   mX_rvalid/rdata          master X read data return
//   s_valid/addr/wmask/wdata DTIM access strobe and command
//   s_rdata                  DTIM read data, valid the cycle after s_valid
//   owner                    current/last owner, for debug

module dtim_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_wmask,
    input  logic [31:0]       m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_wmask,
    input  logic [31:0]       m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              s_valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [3:0]        s_wmask,
    output logic [31:0]       s_wdata,
    input  logic [31:0]       s_rdata,
    output logic              owner
);

    localparam logic [3:0] MAX_C = 4'(MAX_BURST);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_who_q, rd_who_d;

    logic       gnt_any;
    logic       gnt_who;
    logic       own_req, own_lock, oth_req;
    logic       sel;

    // Requests seen from the point of view of the current owner.
    assign own_req  = owner_q ? m1_req  : m0_req;
    assign own_lock = owner_q ? m1_lock : m0_lock;
    assign oth_req  = owner_q ? m0_req  : m1_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b1;   // so master 0 wins the first tie
            burst_cnt_q <= 4'd0;
            rd_pend_q   <= 1'b0;
            rd_who_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_who_q    <= rd_who_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        gnt_any     = 1'b0;
        gnt_who     = owner_q;
        case (state_q)
            IDLE: begin
                if (m0_req | m1_req) begin
                    gnt_any     = 1'b1;
                    // On a tie the non-owner wins; otherwise the lone requester.
                    gnt_who     = (m0_req & m1_req) ? ~owner_q : m1_req;
                    owner_d     = gnt_who;
                    burst_cnt_d = 4'd1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (own_req & own_lock & (burst_cnt_q < MAX_C)) begin
                    gnt_any     = 1'b1;
                    gnt_who     = owner_q;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end else if (oth_req) begin
                    gnt_any     = 1'b1;
                    gnt_who     = ~owner_q;
                    owner_d     = ~owner_q;
                    burst_cnt_d = 4'd1;
                end else if (own_req) begin
                    // Uncontended: keep granting, the burst limit only bites
                    // when the other master is waiting.
                    gnt_any     = 1'b1;
                    gnt_who     = owner_q;
                    burst_cnt_d = (burst_cnt_q < MAX_C) ? burst_cnt_q + 4'd1 : MAX_C;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0_gnt  = gnt_any & ~gnt_who & ~rst;
    assign m1_gnt  = gnt_any &  gnt_who & ~rst;
    assign s_valid = m0_gnt | m1_gnt;

    // Without a grant the command bus parks on the current owner.
    assign sel     = gnt_any ? gnt_who : owner_q;
    assign s_addr  = sel ? m1_addr  : m0_addr;
    assign s_wmask = sel ? m1_wmask : m0_wmask;
    assign s_wdata = sel ? m1_wdata : m0_wdata;

    assign rd_pend_d = s_valid & (s_wmask == 4'd0);
    assign rd_who_d  = m1_gnt;

    assign m0_rvalid = rd_pend_q & ~rd_who_q;
    assign m1_rvalid = rd_pend_q &  rd_who_q;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;

    assign owner = owner_q;

endmodule

// File: tb/tb_dtim_arbiter.sv
// tb/tb_dtim_arbiter.sv - scoreboard testbench for dtim_arbiter

module tb_dtim_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_lock = 1'b0;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
    logic [3:0]  m0_wmask = 4'h0;
    logic        m1_req = 1'b0, m1_lock = 1'b0;
    logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
    logic [3:0]  m1_wmask = 4'h0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wmask;
    logic [31:0] s_rdata = 32'h0;
    logic        owner;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          cyc;
        bit          who;
        logic [31:0] addr;
        logic [3:0]  wmask;
    } gnt_t;

    typedef struct {
        int          cyc;
        bit          who;
        logic [31:0] data;
    } rd_t;

    gnt_t gq[$];
    rd_t  rq[$];

    dtim_arbiter #(.MAX_BURST(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wmask(s_wmask), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .owner(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
    endfunction

    // DTIM model: synchronous read, data valid the cycle after the strobe.
    always @(posedge clk)
        s_rdata <= (s_valid && s_wmask == 4'h0) ? rom(s_addr) : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    // One cycle of stimulus; exp_who: 0/1 = expected winner, 2 = no grant.
    task automatic beat(input bit r0, input bit l0, input logic [3:0] w0, input logic [31:0] a0,
                        input bit r1, input bit l1, input logic [3:0] w1, input logic [31:0] a1,
                        input int exp_who, input bit no_rv = 1'b0);
        gnt_t g;
        rd_t  r;
        m0_req = r0; m0_lock = l0; m0_wmask = w0; m0_addr = a0; m0_wdata = a0 ^ 32'h5555_0000;
        m1_req = r1; m1_lock = l1; m1_wmask = w1; m1_addr = a1; m1_wdata = a1 ^ 32'hAAAA_0000;
        if (exp_who != 2) begin
            g.cyc   = cyc;
            g.who   = (exp_who == 1);
            g.addr  = g.who ? a1 : a0;
            g.wmask = g.who ? w1 : w0;
            gq.push_back(g);
            if (g.wmask == 4'h0 && !no_rv) begin
                r.cyc  = cyc + 1;
                r.who  = g.who;
                r.data = rom(g.addr);
                rq.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        beat(0, 0, 4'h0, 32'h0, 0, 0, 4'h0, 32'h0, 2);
    endtask

    task automatic do_reset();
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("owner_after_reset", {31'h0, owner}, 32'h1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant or read data.
    always @(negedge clk) begin
        gnt_t g;
        rd_t  r;
        if (rst) begin
            check("reset_quiet", {27'h0, m0_gnt, m1_gnt, s_valid, m0_rvalid, m1_rvalid}, 32'h0);
        end else begin
            check("gnt_exclusive", {31'h0, m0_gnt & m1_gnt}, 32'h0);
            check("s_valid_eq_gnt", {31'h0, s_valid}, {31'h0, m0_gnt | m1_gnt});
            if (s_valid) begin
                if (gq.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    g = gq.pop_front();
                    check("gnt_cycle", cyc, g.cyc);
                    check("gnt_who", {31'h0, m1_gnt}, {31'h0, g.who});
                    check("s_addr", s_addr, g.addr);
                    check("s_wmask", {28'h0, s_wmask}, {28'h0, g.wmask});
                end
            end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                g = gq.pop_front();
                check("missing_grant", 32'h0, 32'h1);
            end
            check("rvalid_exclusive", {31'h0, m0_rvalid & m1_rvalid}, 32'h0);
            if (m0_rvalid | m1_rvalid) begin
                if (rq.size() == 0) begin
                    fail_now("unexpected_rvalid");
                end else begin
                    r = rq.pop_front();
                    check("rvalid_cycle", cyc, r.cyc);
                    check("rvalid_who", {31'h0, m1_rvalid}, {31'h0, r.who});
                    check("rdata", m1_rvalid ? m1_rdata : m0_rdata, r.data);
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                r = rq.pop_front();
                check("missing_rvalid", 32'h0, 32'h1);
            end
        end
    end

    initial begin
        do_reset();

        // Simultaneous requests without lock alternate, m0 first.
        for (int i = 0; i < 4; i++)
            beat(1, 0, 4'hF, 32'h100, 1, 0, 4'hF, 32'h200, i % 2);
        idle();

        // Lone m1 read of 0x10 returns 0xDEADBEEF next cycle.
        do_reset();
        beat(0, 0, 4'h0, 32'h0, 1, 0, 4'h0, 32'h10, 1);
        idle();
        idle();

        // Locked m0 writes under contention: 4 beats, then m1, then m0 again.
        do_reset();
        for (int i = 0; i < 4; i++)
            beat(1, 1, 4'hF, 32'h300, 1, 0, 4'hF, 32'h400, 0);
        beat(1, 1, 4'hF, 32'h300, 1, 0, 4'hF, 32'h400, 1);
        beat(1, 1, 4'hF, 32'h300, 1, 0, 4'hF, 32'h400, 0);
        idle();
        // Owner (m0) is kept across IDLE, so a tie now goes to m1.
        beat(1, 0, 4'hF, 32'h304, 1, 0, 4'hF, 32'h404, 1);
        idle();

        // Uncontended locked m0 reads: 10 back-to-back grants, no forced gap.
        do_reset();
        for (int i = 0; i < 10; i++)
            beat(1, 1, 4'h0, 32'h40 + 4 * i, 0, 0, 4'h0, 32'h0, 0);
        idle();
        idle();

        // Reset in the cycle after an m0 read grant drops the read.
        do_reset();
        beat(1, 0, 4'h0, 32'h80, 0, 0, 4'h0, 32'h0, 0, 1'b1);
        do_reset();
        beat(1, 0, 4'hF, 32'h84, 1, 0, 4'hF, 32'h88, 0);
        idle();
        idle();

        // Partial write: single strobe with wmask 0x3 at 0x20, no read return.
        do_reset();
        beat(1, 0, 4'h3, 32'h20, 0, 0, 4'h0, 32'h0, 0);
        idle();
        idle();

        check("grant_queue_drained", gq.size(), 32'h0);
        check("read_queue_drained", rq.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
